// File: rtl/sprite_tile_loader.sv
// Sprite tile loader: packs a CPU stream of 32-bit words into TILE_BITS tile
// rows and writes each complete row to the sprite tile RAM, only during vblank.
// Latency: a row is written 1 cycle after its last word is accepted (vblank=1).
// Backpressure: i_s_ready drops while a row waits for vblank or the loader is idle.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start, i_base_addr,   job launch pulse, first tile address and tile count
//   i_tile_count            (sampled when the loader is idle)
//   i_abort                 cancels the current job; no done, no partial write
//   i_s_valid, i_s_data,    32-bit input stream with valid/ready handshake
//   o_s_ready
//   i_vblank                memory writes permitted while high
//   o_mem_we, o_mem_addr,   registered tile RAM write port; addr/data hold
//   o_mem_wdata             their last written values between strobes
//   o_busy, o_done          job in progress / one-cycle job completion pulse
module sprite_tile_loader #(
    parameter int TILE_BITS = 64,
    parameter int ADDR_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [ADDR_BITS-1:0] i_base_addr,
    input  logic [ADDR_BITS:0]   i_tile_count,
    input  logic                 i_abort,
    input  logic                 i_s_valid,
    input  logic [31:0]          i_s_data,
    output logic                 o_s_ready,
    input  logic                 i_vblank,
    output logic                 o_mem_we,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [TILE_BITS-1:0] o_mem_wdata,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int WPT   = TILE_BITS / 32;
    localparam int IDX_W = (WPT > 1) ? $clog2(WPT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [ADDR_BITS:0]     r_remaining;
    logic [IDX_W-1:0]       r_word_idx;
    logic [TILE_BITS-1:0]   r_pack;
    logic                   r_mem_we;
    logic [ADDR_BITS-1:0]   r_mem_addr;
    logic [TILE_BITS-1:0]   r_mem_wdata;
    logic                   r_done;

    logic                   w_s_ready;
    logic                   w_hs;
    logic                   w_last_word;
    logic                   w_write;
    logic                   w_launch;
    logic                   w_done_set;
    logic                   w_last_tile;

    assign w_last_word = (r_word_idx == IDX_W'(WPT - 1));
    assign w_last_tile = (r_remaining == (ADDR_BITS+1)'(1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort wins over any handshake or commit
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start && (i_tile_count != '0)) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_hs && w_last_word) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (i_vblank) begin
                    w_next_state = w_last_tile ? S_IDLE : S_FILL;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output / control decode. Ready is masked by abort so an aborted cycle
    // never consumes a stream word the upstream believes was taken.
    always_comb begin
        w_s_ready  = (r_state == S_FILL) && !i_abort;
        w_hs       = w_s_ready && i_s_valid;
        w_write    = (r_state == S_COMMIT) && i_vblank && !i_abort;
        w_launch   = (r_state == S_IDLE) && i_start && (i_tile_count != '0);
        w_done_set = ((r_state == S_IDLE) && i_start && (i_tile_count == '0)) ||
                     (w_write && w_last_tile);
    end

    // Datapath: pack register, job counters and registered RAM write port
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_word_idx  <= '0;
            r_pack      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
        end else begin
            r_mem_we <= w_write;
            r_done   <= w_done_set;

            if (w_launch) begin
                r_addr      <= i_base_addr;
                r_remaining <= i_tile_count;
                r_word_idx  <= '0;
            end

            // A cancelled job leaves a fresh slot index for the next one
            if ((r_state != S_IDLE) && i_abort) begin
                r_word_idx <= '0;
            end

            if (w_hs) begin
                r_pack[int'(r_word_idx)*32 +: 32] <= i_s_data;
                r_word_idx <= w_last_word ? '0 : r_word_idx + 1'b1;
            end

            if (w_write) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= r_pack;
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    assign o_s_ready   = w_s_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_sprite_tile_loader.sv
module tb_sprite_tile_loader;

    typedef struct {
        logic [7:0]  a;
        logic [63:0] d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  tile_count;
    logic        abort;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        vblank;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        busy;
    logic        done;

    int  vecs = 0;
    int  errs = 0;
    int  done_cnt = 0;
    int  done_ref;
    wr_t exp_q[$];

    sprite_tile_loader #(.TILE_BITS(64), .ADDR_BITS(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base_addr),
        .i_tile_count (tile_count),
        .i_abort      (abort),
        .i_s_valid    (s_valid),
        .i_s_data     (s_data),
        .o_s_ready    (s_ready),
        .i_vblank     (vblank),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write strobe is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    errs++;
                    $display("FAIL write: got addr %h data %h, required addr %h data %h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
        if (!rst && done) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [63:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] ba, input logic [8:0] cnt);
        start      = 1'b1;
        base_addr  = ba;
        tile_count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 200; t++) begin
            if (s_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!ok) begin
            vecs++;
            errs++;
            $display("FAIL send_timeout: got no s_ready for word %h, required acceptance", d);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk({name, "_idle"}, 64'(ok), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; tile_count = '0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; vblank = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic two-tile job
        done_ref = done_cnt;
        expect_wr(8'h10, 64'h22222222_11111111);
        expect_wr(8'h11, 64'h44444444_33333333);
        do_start(8'h10, 9'd2);
        chk("basic_busy_rise", 64'(busy), 64'd1);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        wait_idle("basic");
        chk("basic_done_once", 64'(done_cnt - done_ref), 64'd1);
        chk("basic_busy_low", 64'(busy), 64'd0);

        // vblank stall of 20 cycles after the second word
        begin
            bit bad;
            bad = 1'b0;
            done_ref = done_cnt;
            vblank = 1'b0;
            expect_wr(8'h10, 64'h22222222_11111111);
            expect_wr(8'h11, 64'h44444444_33333333);
            do_start(8'h10, 9'd2);
            send_word(32'h11111111);
            send_word(32'h22222222);
            for (int i = 0; i < 20; i++) begin
                if (s_ready !== 1'b0 || mem_we !== 1'b0) bad = 1'b1;
                @(negedge clk);
            end
            chk("stall_quiet", 64'(bad), 64'd0);
            vblank = 1'b1;
            @(negedge clk);
            chk("stall_we_after_vblank", 64'(mem_we), 64'd1);
            send_word(32'h33333333);
            send_word(32'h44444444);
            wait_idle("stall");
            chk("stall_done_once", 64'(done_cnt - done_ref), 64'd1);
        end

        // Address wrap
        expect_wr(8'hFF, 64'hBEEF0002_BEEF0001);
        expect_wr(8'h00, 64'hBEEF0004_BEEF0003);
        do_start(8'hFF, 9'd2);
        send_word(32'hBEEF0001);
        send_word(32'hBEEF0002);
        send_word(32'hBEEF0003);
        send_word(32'hBEEF0004);
        wait_idle("wrap");

        // Zero-length job
        begin
            bit busy_seen;
            busy_seen = 1'b0;
            done_ref = done_cnt;
            do_start(8'h55, 9'd0);
            chk("zero_done_pulse", 64'(done), 64'd1);
            for (int i = 0; i < 5; i++) begin
                if (busy) busy_seen = 1'b1;
                @(negedge clk);
            end
            chk("zero_busy_never", 64'(busy_seen), 64'd0);
            chk("zero_done_once", 64'(done_cnt - done_ref), 64'd1);
        end

        // Abort mid-tile, then a clean one-tile job
        done_ref = done_cnt;
        do_start(8'h30, 9'd2);
        send_word(32'hDEADDEAD);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_low", 64'(busy), 64'd0);
        chk("abort_s_ready_low", 64'(s_ready), 64'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - done_ref), 64'd0);
        expect_wr(8'h20, 64'hBBBBBBBB_AAAAAAAA);
        do_start(8'h20, 9'd1);
        send_word(32'hAAAAAAAA);
        send_word(32'hBBBBBBBB);
        wait_idle("post_abort");
        chk("post_abort_done_once", 64'(done_cnt - done_ref), 64'd1);

        // Random valid gaps with stray start pulses while busy
        done_ref = done_cnt;
        expect_wr(8'h40, 64'hC0DE0001_C0DE0000);
        expect_wr(8'h41, 64'hC0DE0003_C0DE0002);
        expect_wr(8'h42, 64'hC0DE0005_C0DE0004);
        do_start(8'h40, 9'd3);
        fork
            begin
                for (int w = 0; w < 6; w++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send_word(32'hC0DE0000 + 32'(w));
                end
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    if (busy) begin
                        start      = 1'b1;
                        base_addr  = 8'h99;
                        tile_count = 9'd5;
                        @(negedge clk);
                        start = 1'b0;
                    end
                end
            end
        join
        wait_idle("rand");
        chk("rand_done_once", 64'(done_cnt - done_ref), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sprite_tile_loader.md
Name: sprite_tile_loader

Overview:
- Writer side of the sprite tile memory that the sprite draw pipeline reads through eight combinational index ports.
- Accepts a CPU-driven stream of 32-bit words, packs them into full tile rows of TILE_BITS and writes each complete row into the sprite tile RAM write port.
- Writes to the RAM are issued only while vblank is high, so the draw pipeline never sees a half-updated tile during active display.
- Sits between the CPU peripheral bridge and the write port of the sprite tile RAM.

Parameters:
TILE_BITS, 64, width of one tile memory word; must be a multiple of 32
ADDR_BITS, 8, tile memory address width (depth 2^ADDR_BITS)
WPT, TILE_BITS/32, stream words per tile word (derived; not overridable)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse; launches a load job when idle
base_addr  input  ADDR_BITS  first tile address of the job, sampled on accepted start
tile_count  input  ADDR_BITS+1  number of tile words in the job, sampled on accepted start; 0 is legal
abort  input  1  one-cycle pulse; cancels the current job
s_valid  input  1  stream word valid
s_data  input  32  stream word
s_ready  output  1  loader accepts s_data this cycle when s_valid&s_ready
vblank  input  1  high while memory writes are permitted
mem_we  output  1  one-cycle write strobe to the tile RAM
mem_addr  output  ADDR_BITS  write address
mem_wdata  output  TILE_BITS  write data
busy  output  1  job in progress
done  output  1  one-cycle pulse when a job completes (not on abort)

Behaviour:
- Reset, asynchronous: state=IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0; the pack register and all counters clear.
- IDLE:
  - start=1 with tile_count>0: latch addr=base_addr, remaining=tile_count, word_idx=0, then go to FILL; busy goes high the next cycle.
  - start=1 with tile_count=0: stay IDLE and pulse done the next cycle; busy stays 0.
  - start is ignored in every state except IDLE.
- FILL: s_ready=1.
  - Each handshake stores s_data at pack bits [32*word_idx+31 : 32*word_idx]; the first word goes to the LSBs.
  - word_idx increments on each handshake.
  - On the handshake with word_idx=WPT-1: word_idx becomes 0 and the state goes to COMMIT.
- COMMIT: s_ready=0.
  - When vblank=1: assert mem_we for exactly one cycle with mem_addr=addr and mem_wdata=pack, registered, so mem_we is visible in the cycle after the COMMIT decision.
  - On that write: addr increments (wraps 2^ADDR_BITS-1 -> 0) and remaining decrements.
  - If remaining reaches 0: go to IDLE, pulse done in the same cycle that busy drops. Otherwise return to FILL.
  - When vblank=0: hold the state, hold pack, mem_we=0, and stall the stream.
- Latency:
  - At the earliest, a tile word is written 1 cycle after its last stream word is accepted, given vblank=1.
  - Minimum throughput is WPT+1 cycles per tile word.
- abort, in any non-IDLE state:
  - Next state is IDLE, busy=0, s_ready=0, no done.
  - Any pending mem_we is suppressed; a partial tile is never written.
  - abort takes priority over a simultaneous handshake or write.
- Output timing: mem_addr and mem_wdata hold their last written values while mem_we=0.
- vblank falling mid-job only stalls the next commit. Words already packed are kept.
- Reset asserted mid-job: the job is discarded and no write is issued after reset.

Test Plan:
- Reset then start with base_addr=0x10, tile_count=2, stream words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (vblank=1) -> mem_we pulses exactly twice: addr 0x10 with data 0x2222222211111111, then addr 0x11 with data 0x4444444433333333; done pulses once; busy returns to 0.
- Same job with vblank=0 held 20 cycles after the second word, then vblank=1 -> s_ready stays 0 and mem_we stays 0 throughout the stall; the write occurs 1 cycle after vblank rises with the correct data.
- base_addr=0xFF, tile_count=2 -> writes go to 0xFF and then 0x00.
- tile_count=0 -> done pulses 1 cycle after start; busy never rises; no mem_we.
- abort after 1 of 2 words of the first tile -> no mem_we, no done; a following job with base_addr=0x20, tile_count=1 writes only its own data at 0x20.
- start pulsed while busy and s_valid toggled randomly -> the in-flight job is unaffected; the word sequence matches a scoreboard.
